// File: rtl/vid_timing_meas.sv
// rtl/vid_timing_meas.sv - measures line/frame timing, pixel checksum and lock of an hs/vs/vld/rgb raster
module vid_timing_meas #(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs,
    input  logic              vs,
    input  logic              vld,
    input  logic [3*PW-1:0]   rgb,
    output logic [H_BITS-1:0] meas_h_total,
    output logic [H_BITS-1:0] meas_h_sync,
    output logic [H_BITS-1:0] meas_h_act,
    output logic [V_BITS-1:0] meas_v_total,
    output logic [V_BITS-1:0] meas_v_sync,
    output logic [V_BITS-1:0] meas_v_act,
    output logic [3*PW-1:0]   meas_sum,
    output logic              meas_vld,
    output logic              locked,
    output logic              mismatch
);
    localparam int SW = 3*PW;
    typedef enum logic {WAIT_VS, MEASURE} state_t;

    function automatic logic [H_BITS-1:0] h_inc(input logic [H_BITS-1:0] x, input logic en);
        return (en && x != '1) ? x + 1'b1 : x;
    endfunction

    function automatic logic [V_BITS-1:0] v_inc(input logic [V_BITS-1:0] x, input logic en);
        return (en && x != '1) ? x + 1'b1 : x;
    endfunction

    state_t            state_q, state_d;
    logic              hs1_q, vs1_q, vld1_q, hs2_q, vs2_q;
    logic [SW-1:0]     rgb1_q;
    logic [H_BITS-1:0] h_cnt_q, h_cnt_d, h_sync_q, h_sync_d, h_act_q, h_act_d;
    logic [H_BITS-1:0] line_total_q, line_total_d, line_sync_q, line_sync_d, last_act_q, last_act_d;
    logic [V_BITS-1:0] v_total_q, v_total_d, v_sync_q, v_sync_d, v_act_q, v_act_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [H_BITS-1:0] res_h_total_q, res_h_total_d, res_h_sync_q, res_h_sync_d, res_h_act_q, res_h_act_d;
    logic [V_BITS-1:0] res_v_total_q, res_v_total_d, res_v_sync_q, res_v_sync_d, res_v_act_q, res_v_act_d;
    logic [SW-1:0]     res_sum_q, res_sum_d;
    logic              res_vld_q, res_vld_d;
    logic [H_BITS-1:0] meas_h_total_q, meas_h_total_d, meas_h_sync_q, meas_h_sync_d, meas_h_act_q, meas_h_act_d;
    logic [V_BITS-1:0] meas_v_total_q, meas_v_total_d, meas_v_sync_q, meas_v_sync_d, meas_v_act_q, meas_v_act_d;
    logic [SW-1:0]     meas_sum_q, meas_sum_d;
    logic              meas_vld_q, meas_vld_d, locked_q, locked_d, mismatch_q, mismatch_d;
    logic              have_prev_q, have_prev_d;

    logic              hs_rise, vs_rise, line_open, same;
    logic [V_BITS-1:0] v_act_closed;
    logic [SW-1:0]     pix;

    always_comb begin
        hs_rise      = hs1_q & ~hs2_q;
        vs_rise      = vs1_q & ~vs2_q;
        line_open    = (h_act_q != '0);
        pix          = vld1_q ? rgb1_q : '0;
        v_act_closed = v_inc(v_act_q, hs_rise & line_open);

        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        h_sync_d      = h_sync_q;
        h_act_d       = h_act_q;
        line_total_d  = line_total_q;
        line_sync_d   = line_sync_q;
        last_act_d    = last_act_q;
        v_total_d     = v_total_q;
        v_sync_d      = v_sync_q;
        v_act_d       = v_act_q;
        sum_d         = sum_q;
        res_h_total_d = res_h_total_q;
        res_h_sync_d  = res_h_sync_q;
        res_h_act_d   = res_h_act_q;
        res_v_total_d = res_v_total_q;
        res_v_sync_d  = res_v_sync_q;
        res_v_act_d   = res_v_act_q;
        res_sum_d     = res_sum_q;
        res_vld_d     = 1'b0;

        // In WAIT_VS everything sits at zero, so the arming edge starts the first frame from a clean base.
        if (state_q == MEASURE || vs_rise) begin
            if (hs_rise) begin
                line_total_d = h_cnt_q;
                line_sync_d  = h_sync_q;
                if (line_open) begin
                    last_act_d = h_act_q;
                end
                h_cnt_d  = H_BITS'(1);
                h_sync_d = H_BITS'(1);
                h_act_d  = H_BITS'(vld1_q);
            end else begin
                h_cnt_d  = h_inc(h_cnt_q, 1'b1);
                h_sync_d = h_inc(h_sync_q, hs1_q);
                h_act_d  = h_inc(h_act_q, vld1_q);
            end

            if (vs_rise) begin
                state_d       = MEASURE;
                res_vld_d     = (state_q == MEASURE);
                res_h_total_d = line_total_d;
                res_h_sync_d  = line_sync_d;
                res_h_act_d   = last_act_d;
                res_v_total_d = v_total_q;
                res_v_sync_d  = v_sync_q;
                res_v_act_d   = v_act_closed;
                res_sum_d     = sum_q;
                v_total_d     = V_BITS'(hs_rise);
                v_sync_d      = V_BITS'(hs_rise & vs1_q);
                v_act_d       = '0;
                sum_d         = pix;
            end else begin
                v_total_d = v_inc(v_total_q, hs_rise);
                v_sync_d  = v_inc(v_sync_q, hs_rise & vs1_q);
                v_act_d   = v_act_closed;
                sum_d     = sum_q + pix;
            end
        end
    end

    // Publish stage: lock compares the new frame against the values currently on the outputs.
    always_comb begin
        meas_h_total_d = meas_h_total_q;
        meas_h_sync_d  = meas_h_sync_q;
        meas_h_act_d   = meas_h_act_q;
        meas_v_total_d = meas_v_total_q;
        meas_v_sync_d  = meas_v_sync_q;
        meas_v_act_d   = meas_v_act_q;
        meas_sum_d     = meas_sum_q;
        meas_vld_d     = res_vld_q;
        locked_d       = locked_q;
        mismatch_d     = 1'b0;
        have_prev_d    = have_prev_q;
        same = have_prev_q && res_h_total_q == meas_h_total_q && res_v_total_q == meas_v_total_q
            && res_h_act_q == meas_h_act_q && res_v_act_q == meas_v_act_q;
        if (res_vld_q) begin
            meas_h_total_d = res_h_total_q;
            meas_h_sync_d  = res_h_sync_q;
            meas_h_act_d   = res_h_act_q;
            meas_v_total_d = res_v_total_q;
            meas_v_sync_d  = res_v_sync_q;
            meas_v_act_d   = res_v_act_q;
            meas_sum_d     = res_sum_q;
            have_prev_d    = 1'b1;
            if (same) begin
                locked_d = 1'b1;
            end else if (locked_q) begin
                locked_d   = 1'b0;
                mismatch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_VS;
            hs1_q <= 1'b0; vs1_q <= 1'b0; vld1_q <= 1'b0; rgb1_q <= '0;
            hs2_q <= 1'b0; vs2_q <= 1'b0;
            h_cnt_q <= '0; h_sync_q <= '0; h_act_q <= '0;
            line_total_q <= '0; line_sync_q <= '0; last_act_q <= '0;
            v_total_q <= '0; v_sync_q <= '0; v_act_q <= '0; sum_q <= '0;
            res_h_total_q <= '0; res_h_sync_q <= '0; res_h_act_q <= '0;
            res_v_total_q <= '0; res_v_sync_q <= '0; res_v_act_q <= '0;
            res_sum_q <= '0; res_vld_q <= 1'b0;
            meas_h_total_q <= '0; meas_h_sync_q <= '0; meas_h_act_q <= '0;
            meas_v_total_q <= '0; meas_v_sync_q <= '0; meas_v_act_q <= '0;
            meas_sum_q <= '0; meas_vld_q <= 1'b0;
            locked_q <= 1'b0; mismatch_q <= 1'b0; have_prev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hs1_q <= hs; vs1_q <= vs; vld1_q <= vld; rgb1_q <= rgb;
            hs2_q <= hs1_q; vs2_q <= vs1_q;
            h_cnt_q <= h_cnt_d; h_sync_q <= h_sync_d; h_act_q <= h_act_d;
            line_total_q <= line_total_d; line_sync_q <= line_sync_d; last_act_q <= last_act_d;
            v_total_q <= v_total_d; v_sync_q <= v_sync_d; v_act_q <= v_act_d; sum_q <= sum_d;
            res_h_total_q <= res_h_total_d; res_h_sync_q <= res_h_sync_d; res_h_act_q <= res_h_act_d;
            res_v_total_q <= res_v_total_d; res_v_sync_q <= res_v_sync_d; res_v_act_q <= res_v_act_d;
            res_sum_q <= res_sum_d; res_vld_q <= res_vld_d;
            meas_h_total_q <= meas_h_total_d; meas_h_sync_q <= meas_h_sync_d; meas_h_act_q <= meas_h_act_d;
            meas_v_total_q <= meas_v_total_d; meas_v_sync_q <= meas_v_sync_d; meas_v_act_q <= meas_v_act_d;
            meas_sum_q <= meas_sum_d; meas_vld_q <= meas_vld_d;
            locked_q <= locked_d; mismatch_q <= mismatch_d; have_prev_q <= have_prev_d;
        end
    end

    assign meas_h_total = meas_h_total_q;
    assign meas_h_sync  = meas_h_sync_q;
    assign meas_h_act   = meas_h_act_q;
    assign meas_v_total = meas_v_total_q;
    assign meas_v_sync  = meas_v_sync_q;
    assign meas_v_act   = meas_v_act_q;
    assign meas_sum     = meas_sum_q;
    assign meas_vld     = meas_vld_q;
    assign locked       = locked_q;
    assign mismatch     = mismatch_q;
endmodule

// File: tb/tb_vid_timing_meas.sv
// tb/tb_vid_timing_meas.sv - table-driven and randomized raster checks of vid_timing_meas
module tb_vid_timing_meas;
    logic        clk = 1'b0;
    logic        rst_n, hs, vs, vld;
    logic [23:0] rgb;
    logic [11:0] meas_h_total, meas_h_sync, meas_h_act, meas_v_total, meas_v_sync, meas_v_act;
    logic [23:0] meas_sum;
    logic        meas_vld, locked, mismatch;

    always #5 clk = ~clk;

    vid_timing_meas dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
        .meas_h_total(meas_h_total), .meas_h_sync(meas_h_sync), .meas_h_act(meas_h_act),
        .meas_v_total(meas_v_total), .meas_v_sync(meas_v_sync), .meas_v_act(meas_v_act),
        .meas_sum(meas_sum), .meas_vld(meas_vld), .locked(locked), .mismatch(mismatch)
    );

    typedef struct {
        int h_tot; int v_tot; int hs_w; int vs_w;
        int x0; int x1; int y0; int y1;
        bit vld_on; int last_len; bit rand_rgb; int rst_line;
    } frame_t;
    typedef struct {
        int h_total; int h_sync; int h_act; int v_total; int v_sync; int v_act; int sum;
        bit locked; bit mismatch;
    } exp_t;
    typedef struct { frame_t f; exp_t e; } vec_t;

    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   vs_stamp = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    bit   m_have_prev;
    bit   m_locked;
    int   m_last_act;
    exp_t m_prev;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_h_total"}, int'(meas_h_total), 0);
        chk({tag, "_h_sync"}, int'(meas_h_sync), 0);
        chk({tag, "_h_act"}, int'(meas_h_act), 0);
        chk({tag, "_v_total"}, int'(meas_v_total), 0);
        chk({tag, "_v_sync"}, int'(meas_v_sync), 0);
        chk({tag, "_v_act"}, int'(meas_v_act), 0);
        chk({tag, "_sum"}, int'(meas_sum), 0);
        chk({tag, "_meas_vld"}, int'(meas_vld), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_mismatch"}, int'(mismatch), 0);
    endtask

    function automatic int sat12(input int x);
        return (x > 4095) ? 4095 : x;
    endfunction

    function automatic void reset_model();
        m_have_prev = 1'b0;
        m_locked    = 1'b0;
        m_last_act  = 0;
    endfunction

    // Reference: what a frame should measure, derived from its geometry rather than the cycle stream.
    function automatic exp_t model_frame(input frame_t f, input logic [23:0] s);
        exp_t e;
        int   act_lines;
        bit   same;
        act_lines = f.vld_on ? (f.y1 - f.y0 + 1) : 0;
        if (act_lines > 0) m_last_act = f.x1 - f.x0 + 1;
        e.h_total  = sat12(f.last_len > 0 ? f.last_len : f.h_tot);
        e.h_sync   = f.hs_w;
        e.h_act    = m_last_act;
        e.v_total  = f.v_tot;
        e.v_sync   = f.vs_w;
        e.v_act    = act_lines;
        e.sum      = int'(s);
        e.mismatch = 1'b0;
        same = m_have_prev && e.h_total == m_prev.h_total && e.v_total == m_prev.v_total
            && e.h_act == m_prev.h_act && e.v_act == m_prev.v_act;
        if (same) m_locked = 1'b1;
        else if (m_locked) begin
            m_locked   = 1'b0;
            e.mismatch = 1'b1;
        end
        e.locked    = m_locked;
        m_prev      = e;
        m_have_prev = 1'b1;
        return e;
    endfunction

    function automatic frame_t mk_frame(input int ht, input int vt, input int hw, input int vw,
                                        input int x0, input int x1, input int y0, input int y1,
                                        input bit von, input int last, input bit rr, input int rl);
        frame_t f;
        f.h_tot = ht; f.v_tot = vt; f.hs_w = hw; f.vs_w = vw;
        f.x0 = x0; f.x1 = x1; f.y0 = y0; f.y1 = y1;
        f.vld_on = von; f.last_len = last; f.rand_rgb = rr; f.rst_line = rl;
        return f;
    endfunction

    function automatic exp_t mk_exp(input int ht, input int hsn, input int ha, input int vt,
                                    input int vsn, input int va, input int s, input bit lk, input bit mm);
        exp_t e;
        e.h_total = ht; e.h_sync = hsn; e.h_act = ha; e.v_total = vt; e.v_sync = vsn;
        e.v_act = va; e.sum = s; e.locked = lk; e.mismatch = mm;
        return e;
    endfunction

    function automatic int urange(input int lo, input int hi);
        return lo + int'($urandom % 32'(hi - lo + 1));
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        int     ht, vt, x0, y0;
        ht = urange(8, 40);
        vt = urange(4, 16);
        x0 = urange(0, ht - 1);
        y0 = urange(0, vt - 2);
        f = mk_frame(ht, vt, urange(1, (ht - 1 < 4) ? ht - 1 : 4), urange(1, (vt - 1 < 3) ? vt - 1 : 3),
                     x0, urange(x0, ht - 1), y0, urange(y0, vt - 2), urange(0, 4) != 0, 0, 1'b1, -1);
        return f;
    endfunction

    task automatic tick(input logic h, input logic v, input logic d, input logic [23:0] c);
        @(posedge clk);
        #1;
        hs = h; vs = v; vld = d; rgb = c;
    endtask

    task automatic send_frame(input frame_t f, input bit use_tbl, input exp_t te);
        logic [23:0] s, c;
        logic        p;
        int          len;
        bit          hit_rst;
        exp_t        e;
        s = '0;
        hit_rst = 1'b0;
        for (int y = 0; y < f.v_tot; y++) begin
            len = (y == f.v_tot - 1 && f.last_len > 0) ? f.last_len : f.h_tot;
            for (int x = 0; x < len; x++) begin
                p = f.vld_on && y >= f.y0 && y <= f.y1 && x >= f.x0 && x <= f.x1;
                c = f.rand_rgb ? 24'($urandom) : 24'h010203;
                tick(x < f.hs_w, y < f.vs_w, p, p ? c : 24'h0);
                if (x == 0 && y == 0) vs_stamp = ncyc;
                if (p) s = s + c;
                if (y == f.rst_line && x == 5) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("mid_reset");
                    reset_model();
                    hit_rst = 1'b1;
                end
                if (y == f.rst_line && x == 8) rst_n = 1'b1;
            end
        end
        if (!hit_rst) begin
            e = model_frame(f, s);
            exp_q.push_back(use_tbl ? te : e);
        end
    endtask

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (mismatch && !meas_vld) begin
            total++;
            bad++;
            $display("FAIL mismatch_without_meas_vld: got mismatch=1 expected 0");
        end
        if (meas_vld) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_meas_vld: got meas_vld=1 expected 0 at cycle %0d", ncyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("h_total", int'(meas_h_total), mon_e.h_total);
                chk("h_sync", int'(meas_h_sync), mon_e.h_sync);
                chk("h_act", int'(meas_h_act), mon_e.h_act);
                chk("v_total", int'(meas_v_total), mon_e.v_total);
                chk("v_sync", int'(meas_v_sync), mon_e.v_sync);
                chk("v_act", int'(meas_v_act), mon_e.v_act);
                chk("sum", int'(meas_sum), mon_e.sum);
                chk("locked", int'(locked), int'(mon_e.locked));
                chk("mismatch", int'(mismatch), int'(mon_e.mismatch));
                chk("latency", ncyc - vs_stamp, 4);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t   tbl[11];
        frame_t std_f, f;
        exp_t   none;
        int     sum_std;
        sum_std = 24'h3C78B4;
        none = mk_exp(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        std_f = mk_frame(16, 11, 2, 2, 4, 13, 3, 8, 1'b1, 0, 1'b0, -1);
        for (int i = 0; i < 11; i++) tbl[i].f = std_f;
        tbl[3].f.v_tot    = 12;
        tbl[6].f.vld_on   = 1'b0;
        tbl[8].f.last_len = 5000;
        tbl[0].e  = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b0, 1'b0);
        tbl[1].e  = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b1, 1'b0);
        tbl[2].e  = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b1, 1'b0);
        tbl[3].e  = mk_exp(16, 2, 10, 12, 2, 6, sum_std, 1'b0, 1'b1);
        tbl[4].e  = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b0, 1'b0);
        tbl[5].e  = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b1, 1'b0);
        tbl[6].e  = mk_exp(16, 2, 10, 11, 2, 0, 0, 1'b0, 1'b1);
        tbl[7].e  = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b0, 1'b0);
        tbl[8].e  = mk_exp(4095, 2, 10, 11, 2, 6, sum_std, 1'b0, 1'b0);
        tbl[9].e  = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b0, 1'b0);
        tbl[10].e = mk_exp(16, 2, 10, 11, 2, 6, sum_std, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) send_frame(tbl[i].f, 1'b1, tbl[i].e);

        // Two locked frames, reset in the middle of the third, then one frame that only re-arms.
        send_frame(std_f, 1'b0, none);
        send_frame(std_f, 1'b0, none);
        f = std_f;
        f.rst_line = 5;
        send_frame(f, 1'b0, none);
        send_frame(std_f, 1'b0, none);

        f = rand_frame();
        for (int i = 0; i < 30; i++) begin
            if (i > 0 && $urandom_range(1, 0) == 0) f = rand_frame();
            send_frame(f, 1'b0, none);
        end

        tick(1'b1, 1'b1, 1'b0, 24'h0);
        vs_stamp = ncyc;
        repeat (10) tick(1'b0, 1'b0, 1'b0, 24'h0);
        chk("pending_results", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
